// File: rtl/tz_scanner_if.sv
// Handshake bundle for tz_scanner: upstream word in, trailing-zero result out.
// busy travels with the bundle so the consumer sees scan activity alongside the result.
interface tz_scanner_if #(
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(WIDTH) + 1
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_n;
    logic [CW-1:0]    out_cnt;
    logic             busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_d, out_n, out_cnt, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_d, out_n, out_cnt, busy
    );
endinterface

// File: rtl/tz_scanner.sv
// Bit-serial lowest-set-bit scanner: one word in, one-hot mask and index out.
// Optional macro TZ_SCANNER_EARLY_EXIT_EN ends the scan as soon as the first set bit is seen.
//
// state  | meaning
// S_IDLE | waiting for an upstream word (in_ready high once out of reset)
// S_SCAN | testing one bit per cycle, lowest bit first
// S_DONE | result held on out_* until the downstream handshake
module tz_scanner #(
    parameter int WIDTH = 16
) (
    input logic         clk,
    input logic         rst,
    tz_scanner_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ZERO_CNT = CW'(WIDTH);
    localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_scan;
    logic [CW-1:0]    r_idx;
    logic             r_found;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_n;
    logic [CW-1:0]    r_cnt;
    logic             r_armed;

    state_t           w_state_nx;
    logic [WIDTH-1:0] w_scan_nx;
    logic [CW-1:0]    w_idx_nx;
    logic             w_found_nx;
    logic [WIDTH-1:0] w_d_nx;
    logic [WIDTH-1:0] w_n_nx;
    logic [CW-1:0]    w_cnt_nx;
    logic             w_hit;
    logic             w_accept;

    // in_ready must stay low during reset and rise only on the first edge after release
    assign bus.in_ready  = r_armed && (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.out_d     = r_d;
    assign bus.out_n     = r_n;
    assign bus.out_cnt   = r_cnt;

    assign w_accept = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_scan  <= '0;
            r_idx   <= '0;
            r_found <= 1'b0;
            r_d     <= '0;
            r_n     <= '0;
            r_cnt   <= '0;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_scan  <= w_scan_nx;
            r_idx   <= w_idx_nx;
            r_found <= w_found_nx;
            r_d     <= w_d_nx;
            r_n     <= w_n_nx;
            r_cnt   <= w_cnt_nx;
            r_armed <= 1'b1;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_scan_nx  = r_scan;
        w_idx_nx   = r_idx;
        w_found_nx = r_found;
        w_d_nx     = r_d;
        w_n_nx     = r_n;
        w_cnt_nx   = r_cnt;
        w_hit      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_d_nx     = bus.in_data;
                    w_scan_nx  = bus.in_data;
                    w_idx_nx   = '0;
                    w_found_nx = 1'b0;
                    w_n_nx     = '0;
                    w_cnt_nx   = '0;
                    w_state_nx = S_SCAN;
                end
            end

            S_SCAN: begin
                w_hit     = r_scan[0] && !r_found;
                w_scan_nx = r_scan >> 1;
                w_idx_nx  = r_idx + CW'(1);
                if (w_hit) begin
                    w_found_nx = 1'b1;
                    w_n_nx     = ONE << r_idx;
                    w_cnt_nx   = r_idx;
                end
`ifdef TZ_SCANNER_EARLY_EXIT_EN
                if (w_hit) begin
                    w_state_nx = S_DONE;
                end
`endif
                // Last bit position: close out, reporting an all-zero word if nothing was found
                if (r_idx == LAST_IDX) begin
                    if (!r_found && !r_scan[0]) begin
                        w_n_nx   = '0;
                        w_cnt_nx = ZERO_CNT;
                    end
                    w_state_nx = S_DONE;
                end
            end

            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_nx = S_IDLE;
                end
            end

            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_tz_scanner.sv
// Self-checking bench for tz_scanner: directed vectors, random words, reset mid-scan.
// Expected results come from an arithmetic lowest-set-bit model.
module tb_tz_scanner;
    localparam int WIDTH = 16;
    localparam int CW    = $clog2(WIDTH) + 1;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    tz_scanner_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

    tz_scanner #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lowest set bit isolated by two's complement; index recovered from the one-hot mask
    function automatic void ref_model(input logic [WIDTH-1:0] d,
                                      output logic [WIDTH-1:0] n,
                                      output logic [CW-1:0] c,
                                      output int lat);
        n = d & (~d + 1'b1);
        c = (n == 0) ? CW'(WIDTH) : CW'($clog2(n));
`ifdef TZ_SCANNER_EARLY_EXIT_EN
        lat = (d == 0) ? WIDTH + 1 : int'(c) + 2;
`else
        lat = WIDTH + 1;
`endif
    endfunction

    // Called just after a falling edge; returns just after a falling edge with the DUT idle
    task automatic run_word(input logic [WIDTH-1:0] d, input int hold, input logic junk);
        logic [WIDTH-1:0] en;
        logic [CW-1:0]    ec;
        int               elat;
        int               lat;
        ref_model(d, en, ec, elat);

        bus.in_valid = 1'b1;
        bus.in_data  = d;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL accept_ready d=%h got=%b want=1", d, bus.in_ready);
        else n_pass++;

        @(negedge clk);
        bus.in_valid = junk;
        bus.in_data  = WIDTH'($urandom);
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat <= WIDTH + 4) begin
            @(negedge clk);
            bus.in_data = WIDTH'($urandom);
            lat++;
        end

        n_checks++;
        if (lat !== elat) $display("FAIL latency d=%h got=%0d want=%0d", d, lat, elat);
        else n_pass++;
        n_checks++;
        if (bus.out_d !== d) $display("FAIL out_d d=%h got=%h want=%h", d, bus.out_d, d);
        else n_pass++;
        n_checks++;
        if (bus.out_n !== en) $display("FAIL out_n d=%h got=%h want=%h", d, bus.out_n, en);
        else n_pass++;
        n_checks++;
        if (bus.out_cnt !== ec) $display("FAIL out_cnt d=%h got=%0d want=%0d", d, bus.out_cnt, ec);
        else n_pass++;
        n_checks++;
        if ({bus.busy, bus.in_ready} !== 2'b10)
            $display("FAIL done_flags d=%h got busy/ready=%b%b want=10", d, bus.busy, bus.in_ready);
        else n_pass++;

        repeat (hold) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'h0003;
            @(negedge clk);
            n_checks++;
            if ({bus.out_valid, bus.out_d, bus.out_n, bus.out_cnt} !== {1'b1, d, en, ec})
                $display("FAIL hold d=%h got v=%b d=%h n=%h c=%0d want v=1 d=%h n=%h c=%0d",
                         d, bus.out_valid, bus.out_d, bus.out_n, bus.out_cnt, d, en, ec);
            else n_pass++;
        end

        // Handshake cycle with a word offered: it must not be taken
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = WIDTH'($urandom);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        n_checks++;
        if ({bus.out_valid, bus.busy, bus.in_ready} !== 3'b001)
            $display("FAIL after_hs d=%h got valid/busy/ready=%b%b%b want=001",
                     d, bus.out_valid, bus.busy, bus.in_ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #3;
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.busy, bus.out_d, bus.out_n, bus.out_cnt} !== '0)
            $display("FAIL reset_state got r=%b v=%b b=%b d=%h n=%h c=%0d want all 0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.out_d, bus.out_n, bus.out_cnt);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b0) $display("FAIL ready_in_reset got=%b want=0", bus.in_ready);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b0) $display("FAIL ready_at_release got=%b want=0", bus.in_ready);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL ready_after_edge got=%b want=1", bus.in_ready);
        else n_pass++;
    endtask

    task automatic test_directed();
        run_word(16'h0001, 1, 1'b1);
        run_word(16'hA8C0, 2, 1'b1);
        run_word(16'h0000, 0, 1'b1);
        run_word(16'h8000, 5, 1'b1);
        run_word(16'hFFFF, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] d;
        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(0, 3))
                0:       d = '0;
                1:       d = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
                2:       d = WIDTH'($urandom);
                default: d = WIDTH'($urandom) << $urandom_range(0, WIDTH - 1);
            endcase
            run_word(d, int'($urandom_range(0, 3)), 1'($urandom));
        end
    endtask

    task automatic test_reset_mid_scan();
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h4000;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.busy, bus.out_d, bus.out_n, bus.out_cnt} !== '0)
            $display("FAIL mid_scan_reset got r=%b v=%b b=%b d=%h n=%h c=%0d want all 0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.out_d, bus.out_n, bus.out_cnt);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.in_ready} !== 2'b01)
            $display("FAIL post_reset_idle got busy/ready=%b%b want=01", bus.busy, bus.in_ready);
        else n_pass++;
        run_word(16'h0004, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            run_word(WIDTH'($urandom) | 16'h0100, 0, 1'b1);
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_directed();
        test_random();
        test_reset_mid_scan();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/tz_scanner.md
TZ_SCANNER -- requirements
Module: tz_scanner

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width; count width CW = clog2(WIDTH)+1 (5 at default).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  upstream word present.
REQ-005 SHALL have port in_ready  output  1  block accepts a word this cycle.
REQ-006 SHALL have port in_data  input  WIDTH  word to scan.
REQ-007 SHALL have port out_valid  output  1  result present.
REQ-008 SHALL have port out_ready  input  1  downstream shifter takes result.
REQ-009 SHALL have port out_d  output  WIDTH  captured in_data, unmodified.
REQ-010 SHALL have port out_n  output  WIDTH  one-hot mask of lowest set bit of out_d; all-zero if out_d==0.
REQ-011 SHALL have port out_cnt  output  CW  index of lowest set bit; WIDTH if out_d==0.
REQ-012 SHALL have port busy  output  1  high in SCAN or DONE.

Function
REQ-013 SHALL implement three states: IDLE, SCAN, DONE.
REQ-014 IDLE: in_ready=1; on in_valid&in_ready, SHALL capture in_data into out_d and a scan register, clear idx to 0, and enter SCAN.
REQ-015 SCAN: each cycle SHALL test scan[0]; if set and no bit found yet, record out_n=1<<idx and out_cnt=idx.
REQ-016 SCAN: if scan[0] clear, SHALL shift the scan register right by 1 (zero fill) and increment idx.
REQ-017 SCAN: if idx==WIDTH-1 and no set bit found, SHALL set out_n=0 and out_cnt=WIDTH and enter DONE.
REQ-018 DONE: out_valid=1; out_d, out_n and out_cnt SHALL hold stable until out_valid&out_ready, then enter IDLE.
REQ-019 in_ready SHALL be 0 in SCAN and DONE; in_valid there SHALL be ignored, with no capture.
REQ-020 No input SHALL be accepted in the same cycle as the output handshake; the earliest next acceptance is the cycle after returning to IDLE.
REQ-021 out_n SHALL always be one-hot or zero, and SHALL be consistent with out_cnt (out_n==0 iff out_cnt==WIDTH).
REQ-022 out_valid SHALL be 0 in IDLE and SCAN; out_d SHALL not change between capture and handshake.

Reset
REQ-023 On rst high, regardless of clock or state (including mid-SCAN), the block SHALL enter IDLE, discard any in-flight word, and set out_valid=0, busy=0, out_d=0, out_n=0, out_cnt=0, idx=0.
REQ-024 On rst high, in_ready SHALL be 0 while rst is asserted and SHALL be 1 from the first clock edge after deassertion.

Configuration
REQ-025 Macro TZ_SCANNER_EARLY_EXIT_EN, when defined: SCAN SHALL enter DONE in the cycle after the first set bit is found; SCAN lasts out_cnt+1 cycles (WIDTH cycles for zero input).
REQ-026 Without TZ_SCANNER_EARLY_EXIT_EN: SCAN SHALL always last exactly WIDTH cycles; the first set bit found is latched and later bits are ignored (fixed latency).

Verification
REQ-027 in_data=16'h0001 with EARLY_EXIT -> out_n=16'h0001, out_cnt=0, out_valid 2 cycles after acceptance; without macro -> 17 cycles.
REQ-028 in_data=16'hA8C0 -> out_n=16'h0040, out_cnt=6, out_d=16'hA8C0; with EARLY_EXIT, out_valid 8 cycles after acceptance.
REQ-029 in_data=16'h0000 -> out_n=0, out_cnt=16, out_valid 17 cycles after acceptance in both builds.
REQ-030 in_data=16'h8000 with out_ready held low 5 cycles in DONE -> outputs stable (out_n=16'h8000, out_cnt=15); in_valid with 16'h0003 during DONE is ignored.
REQ-031 Assert rst mid-SCAN of 16'h4000 -> out_valid=0, busy=0, all outputs 0 immediately; a new word 16'h0004 after release yields out_cnt=2.
